riscv_dport_arb: RTL and testbench
==================================

RISCV_DPORT_ARB -- requirements
Module: riscv_dport_arb

Interface
REQ-001 SHALL have parameter OUTSTANDING, default 2: maximum accepted-but-unacknowledged requests, legal 1..8.
REQ-002 SHALL have port clk_i  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports p0_addr_i / p1_addr_i  in  32  requester address (p0 = LSU, p1 = secondary master).
REQ-005 SHALL have ports pN_data_wr_i  in  32  write data.
REQ-006 SHALL have ports pN_rd_i  in  1  read strobe.
REQ-007 SHALL have ports pN_wr_i  in  4  byte write enables.
REQ-008 SHALL have ports pN_cacheable_i, pN_invalidate_i, pN_flush_i  in  1  request attributes.
REQ-009 SHALL have ports pN_req_tag_i  in  11  opaque request tag.
REQ-010 SHALL have ports pN_accept_o  out  1  request taken this cycle.
REQ-011 SHALL have ports pN_ack_o, pN_error_o  out  1  routed response strobe and error.
REQ-012 SHALL have ports pN_resp_tag_o  out  11  and pN_data_rd_o  out  32  routed response tag and data.
REQ-013 SHALL have ports mem_addr_o, mem_data_wr_o  out  32; mem_rd_o, mem_cacheable_o, mem_invalidate_o, mem_flush_o  out  1; mem_wr_o  out  4; mem_req_tag_o  out  11  shared memory request.
REQ-014 SHALL have ports mem_accept_i, mem_ack_i, mem_error_i  in  1; mem_resp_tag_i  in  11; mem_data_rd_i  in  32  shared memory response.

Function
REQ-015 SHALL treat port N as requesting when pN_rd_i | (pN_wr_i != 0) | pN_flush_i | pN_invalidate_i.
REQ-016 SHALL forward the winner's request combinationally to mem_* in the same cycle (zero latency); with no winner all mem strobes are 0 and data/address/tag fields are 0.
REQ-017 SHALL arbitrate round-robin: after an accept, the accepted port becomes lowest priority; after reset, p0 has priority.
REQ-018 SHALL use state machine IDLE/LOCKED: IDLE -> LOCKED when the winner requests and mem_accept_i = 0; LOCKED holds the grant to that port regardless of the other port; LOCKED -> IDLE on mem_accept_i = 1.
REQ-019 SHALL assert pN_accept_o = mem_accept_i only for the granted, requesting port; the other port's accept is 0.
REQ-020 SHALL push the granted port ID into an in-order source FIFO of depth OUTSTANDING on every accept.
REQ-021 SHALL, with the FIFO full, forward no request (mem strobes 0, both accepts 0), even if mem_ack_i is high that cycle; LOCKED state is retained.
REQ-022 SHALL route mem_ack_i, mem_error_i, mem_resp_tag_i and mem_data_rd_i to the port at the FIFO head and pop it in the same cycle; the other port's ack/error are 0 and its data/tag are 0.
REQ-023 SHALL ignore mem_ack_i while the FIFO is empty: no pN_ack_o and no state change.
REQ-024 SHALL leave the FIFO count unchanged on a simultaneous push and pop; the FIFO pointers wrap modulo OUTSTANDING.
REQ-025 SHALL count every accepted request type (read, write, flush, invalidate) as expecting exactly one mem_ack_i.

Reset
REQ-026 SHALL, while rst_i is high at a clock edge, set state to IDLE, the priority pointer to p0, and the FIFO to empty; all pN_accept_o, pN_ack_o, pN_error_o and mem strobes SHALL read 0 in the following cycle.
REQ-027 SHALL, on reset mid-operation, discard outstanding entries; responses arriving after reset SHALL be dropped under REQ-023.

Structure
REQ-028 SHALL place the port-ID constants, the tag width (11) and the OUTSTANDING bound in the shared riscv_def.v definitions file.
REQ-029 SHALL implement the source-ID FIFO as one sub-module, riscv_arb_fifo (push, pop, full, empty, head).

Verification
REQ-030 SHALL cover: p0 read at 0x100 and p1 write at 0x200 in the same cycle, both accepted immediately after reset -> p0 granted first, p1 next cycle, acks routed p0 then p1.
REQ-031 SHALL cover: p1 requesting while mem_accept_i is held 0 for 3 cycles and p0 asserts mid-stall -> mem_addr_o stays at p1's address until accept; p0 is granted afterwards.
REQ-032 SHALL cover: OUTSTANDING=2, three back-to-back p0 reads with no ack -> third read blocked (p0_accept_o = 0, mem_rd_o = 0) until the first ack.
REQ-033 SHALL cover: ack with mem_error_i=1 and resp_tag 0x2A5 for a p1 entry at the FIFO head -> p1_error_o=1, p1_resp_tag_o=0x2A5, p0_ack_o=0.
REQ-034 SHALL cover: rst_i asserted with 2 outstanding, then a stray mem_ack_i -> no pN_ack_o, FIFO empty, p0 priority.
REQ-035 SHALL cover: push and pop in the same cycle at full count -> count unchanged and entries stay in order.

Source files
------------

// File: rtl/riscv_dport_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: port IDs, tag width,
// outstanding-request bounds and the arbiter FSM state type.
package riscv_dport_arb_pkg;

  localparam int TAG_W           = 11;
  localparam int OUTSTANDING_MIN = 1;
  localparam int OUTSTANDING_MAX = 8;
  localparam int CNT_W           = 4;

  localparam logic PORT_P0 = 1'b0;
  localparam logic PORT_P1 = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/riscv_arb_fifo.sv
// In-order FIFO of granted port IDs; one entry per accepted request, popped
// as each memory response comes back.
module riscv_arb_fifo
  import riscv_dport_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             push_id_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             r_ids [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) return '0;
    return ptr + PTR_W'(1);
  endfunction

  assign full_o    = (r_count == CNT_W'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign head_o    = r_ids[r_rd_ptr];
  assign count_o   = r_count;
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_ids[r_wr_ptr] <= push_id_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/riscv_dport_arb.sv
// Round-robin arbiter sharing one memory port between the LSU (p0) and a
// secondary master (p1); responses are routed back in order via a source FIFO.
module riscv_dport_arb
  import riscv_dport_arb_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      p0_addr_i,
  input  logic [31:0]      p0_data_wr_i,
  input  logic             p0_rd_i,
  input  logic [3:0]       p0_wr_i,
  input  logic             p0_cacheable_i,
  input  logic             p0_invalidate_i,
  input  logic             p0_flush_i,
  input  logic [TAG_W-1:0] p0_req_tag_i,
  output logic             p0_accept_o,
  output logic             p0_ack_o,
  output logic             p0_error_o,
  output logic [TAG_W-1:0] p0_resp_tag_o,
  output logic [31:0]      p0_data_rd_o,
  input  logic [31:0]      p1_addr_i,
  input  logic [31:0]      p1_data_wr_i,
  input  logic             p1_rd_i,
  input  logic [3:0]       p1_wr_i,
  input  logic             p1_cacheable_i,
  input  logic             p1_invalidate_i,
  input  logic             p1_flush_i,
  input  logic [TAG_W-1:0] p1_req_tag_i,
  output logic             p1_accept_o,
  output logic             p1_ack_o,
  output logic             p1_error_o,
  output logic [TAG_W-1:0] p1_resp_tag_o,
  output logic [31:0]      p1_data_rd_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_wr_o,
  output logic             mem_rd_o,
  output logic [3:0]       mem_wr_o,
  output logic             mem_cacheable_o,
  output logic             mem_invalidate_o,
  output logic             mem_flush_o,
  output logic [TAG_W-1:0] mem_req_tag_o,
  input  logic             mem_accept_i,
  input  logic             mem_ack_i,
  input  logic             mem_error_i,
  input  logic [TAG_W-1:0] mem_resp_tag_i,
  input  logic [31:0]      mem_data_rd_i,
  output logic             dbg_state_o,
  output logic [CNT_W-1:0] dbg_count_o
);

  localparam int DEPTH = (OUTSTANDING < OUTSTANDING_MIN) ? OUTSTANDING_MIN :
                         (OUTSTANDING > OUTSTANDING_MAX) ? OUTSTANDING_MAX : OUTSTANDING;

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic             r_lock_port;
  logic             w_lock_nxt;
  logic             r_prio;
  logic             w_req0;
  logic             w_req1;
  logic             w_grant;
  logic             w_win_req;
  logic             w_fwd;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_head;
  logic [CNT_W-1:0] w_count;

  assign w_req0 = p0_rd_i | (|p0_wr_i) | p0_flush_i | p0_invalidate_i;
  assign w_req1 = p1_rd_i | (|p1_wr_i) | p1_flush_i | p1_invalidate_i;

  always_comb begin
    w_grant = PORT_P0;
    if (r_state == ST_LOCKED)  w_grant = r_lock_port;
    else if (w_req0 && w_req1) w_grant = r_prio;
    else if (w_req1)           w_grant = PORT_P1;
  end

  // Handshake: a request is taken in any cycle where it is forwarded on
  // mem_* and mem_accept_i is high; a full source FIFO suppresses forwarding.
  assign w_win_req   = (w_grant == PORT_P1) ? w_req1 : w_req0;
  assign w_fwd       = w_win_req && !w_full;
  assign w_push      = w_fwd && mem_accept_i;
  assign w_pop       = mem_ack_i && !w_empty;
  assign p0_accept_o = w_push && (w_grant == PORT_P0);
  assign p1_accept_o = w_push && (w_grant == PORT_P1);
  assign dbg_state_o = r_state;
  assign dbg_count_o = w_count;

  always_comb begin
    mem_addr_o       = '0;
    mem_data_wr_o    = '0;
    mem_rd_o         = 1'b0;
    mem_wr_o         = '0;
    mem_cacheable_o  = 1'b0;
    mem_invalidate_o = 1'b0;
    mem_flush_o      = 1'b0;
    mem_req_tag_o    = '0;
    if (w_fwd) begin
      if (w_grant == PORT_P1) begin
        mem_addr_o       = p1_addr_i;
        mem_data_wr_o    = p1_data_wr_i;
        mem_rd_o         = p1_rd_i;
        mem_wr_o         = p1_wr_i;
        mem_cacheable_o  = p1_cacheable_i;
        mem_invalidate_o = p1_invalidate_i;
        mem_flush_o      = p1_flush_i;
        mem_req_tag_o    = p1_req_tag_i;
      end else begin
        mem_addr_o       = p0_addr_i;
        mem_data_wr_o    = p0_data_wr_i;
        mem_rd_o         = p0_rd_i;
        mem_wr_o         = p0_wr_i;
        mem_cacheable_o  = p0_cacheable_i;
        mem_invalidate_o = p0_invalidate_i;
        mem_flush_o      = p0_flush_i;
        mem_req_tag_o    = p0_req_tag_i;
      end
    end
  end

  always_comb begin
    p0_ack_o      = 1'b0;
    p0_error_o    = 1'b0;
    p0_resp_tag_o = '0;
    p0_data_rd_o  = '0;
    p1_ack_o      = 1'b0;
    p1_error_o    = 1'b0;
    p1_resp_tag_o = '0;
    p1_data_rd_o  = '0;
    if (w_pop) begin
      if (w_head == PORT_P1) begin
        p1_ack_o      = 1'b1;
        p1_error_o    = mem_error_i;
        p1_resp_tag_o = mem_resp_tag_i;
        p1_data_rd_o  = mem_data_rd_i;
      end else begin
        p0_ack_o      = 1'b1;
        p0_error_o    = mem_error_i;
        p0_resp_tag_o = mem_resp_tag_i;
        p0_data_rd_o  = mem_data_rd_i;
      end
    end
  end

  // A stalled request keeps the grant so mem_* stays stable until accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_port;
    case (r_state)
      ST_IDLE: begin
        if (w_fwd && !mem_accept_i) begin
          w_state_nxt = ST_LOCKED;
          w_lock_nxt  = w_grant;
        end
      end
      ST_LOCKED: begin
        if (w_push) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_lock_port <= PORT_P0;
      r_prio      <= PORT_P0;
    end else begin
      r_state     <= w_state_nxt;
      r_lock_port <= w_lock_nxt;
      if (w_push) r_prio <= ~w_grant;
    end
  end

  riscv_arb_fifo #(
    .DEPTH(DEPTH)
  ) u_src_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (w_push),
    .push_id_i (w_grant),
    .pop_i     (w_pop),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .head_o    (w_head),
    .count_o   (w_count)
  );

endmodule

// File: tb/tb_riscv_dport_arb.sv
// Bench for riscv_dport_arb: directed scenarios with an in-order scoreboard of
// {port, tag} entries checked against routed responses.
module tb_riscv_dport_arb;
  import riscv_dport_arb_pkg::*;

  localparam int OUTSTANDING = 2;

  logic        clk;
  logic        rst;
  logic [31:0] p0_addr, p0_data_wr, p1_addr, p1_data_wr;
  logic        p0_rd, p0_cach, p0_inv, p0_flush;
  logic        p1_rd, p1_cach, p1_inv, p1_flush;
  logic [3:0]  p0_wr, p1_wr;
  logic [10:0] p0_req_tag, p1_req_tag;
  logic        p0_accept_o, p0_ack_o, p0_error_o;
  logic        p1_accept_o, p1_ack_o, p1_error_o;
  logic [10:0] p0_resp_tag_o, p1_resp_tag_o;
  logic [31:0] p0_data_rd_o, p1_data_rd_o;
  logic [31:0] mem_addr_o, mem_data_wr_o;
  logic        mem_rd_o, mem_cacheable_o, mem_invalidate_o, mem_flush_o;
  logic [3:0]  mem_wr_o;
  logic [10:0] mem_req_tag_o;
  logic        mem_accept, mem_ack, mem_error;
  logic [10:0] mem_resp_tag;
  logic [31:0] mem_data_rd;
  logic        dbg_state_o;
  logic [3:0]  dbg_count_o;

  logic [11:0] exp_q[$];
  logic [11:0] e;
  int          total;
  int          bad;

  riscv_dport_arb #(.OUTSTANDING(OUTSTANDING)) dut (
    .clk_i(clk), .rst_i(rst),
    .p0_addr_i(p0_addr), .p0_data_wr_i(p0_data_wr), .p0_rd_i(p0_rd), .p0_wr_i(p0_wr),
    .p0_cacheable_i(p0_cach), .p0_invalidate_i(p0_inv), .p0_flush_i(p0_flush),
    .p0_req_tag_i(p0_req_tag), .p0_accept_o(p0_accept_o), .p0_ack_o(p0_ack_o),
    .p0_error_o(p0_error_o), .p0_resp_tag_o(p0_resp_tag_o), .p0_data_rd_o(p0_data_rd_o),
    .p1_addr_i(p1_addr), .p1_data_wr_i(p1_data_wr), .p1_rd_i(p1_rd), .p1_wr_i(p1_wr),
    .p1_cacheable_i(p1_cach), .p1_invalidate_i(p1_inv), .p1_flush_i(p1_flush),
    .p1_req_tag_i(p1_req_tag), .p1_accept_o(p1_accept_o), .p1_ack_o(p1_ack_o),
    .p1_error_o(p1_error_o), .p1_resp_tag_o(p1_resp_tag_o), .p1_data_rd_o(p1_data_rd_o),
    .mem_addr_o(mem_addr_o), .mem_data_wr_o(mem_data_wr_o), .mem_rd_o(mem_rd_o),
    .mem_wr_o(mem_wr_o), .mem_cacheable_o(mem_cacheable_o),
    .mem_invalidate_o(mem_invalidate_o), .mem_flush_o(mem_flush_o),
    .mem_req_tag_o(mem_req_tag_o), .mem_accept_i(mem_accept), .mem_ack_i(mem_ack),
    .mem_error_i(mem_error), .mem_resp_tag_i(mem_resp_tag), .mem_data_rd_i(mem_data_rd),
    .dbg_state_o(dbg_state_o), .dbg_count_o(dbg_count_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drv_p0(input logic rd, input logic [3:0] wr, input logic fl, input logic inv,
                        input logic [31:0] addr, input logic [31:0] data, input logic [10:0] tag);
    p0_rd = rd; p0_wr = wr; p0_flush = fl; p0_inv = inv;
    p0_addr = addr; p0_data_wr = data; p0_req_tag = tag; p0_cach = rd;
  endtask

  task automatic drv_p1(input logic rd, input logic [3:0] wr, input logic fl, input logic inv,
                        input logic [31:0] addr, input logic [31:0] data, input logic [10:0] tag);
    p1_rd = rd; p1_wr = wr; p1_flush = fl; p1_inv = inv;
    p1_addr = addr; p1_data_wr = data; p1_req_tag = tag; p1_cach = rd;
  endtask

  task automatic drv_mem(input logic acc, input logic ack, input logic err,
                         input logic [10:0] rtag, input logic [31:0] rdata);
    mem_accept = acc; mem_ack = ack; mem_error = err;
    mem_resp_tag = rtag; mem_data_rd = rdata;
  endtask

  task automatic idle_all();
    drv_p0(1'b0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 11'h0);
    drv_p1(1'b0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 11'h0);
    drv_mem(1'b0, 1'b0, 1'b0, 11'h0, 32'h0);
  endtask

  task automatic apply_reset();
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    drv_p0(1'b0, 4'h0, 1'b0, 1'b0, 32'h1234, 32'h5678, 11'h155);
    drv_mem(1'b1, 1'b1, 1'b0, 11'h7, 32'h9);
    #2;
    total++; if ({p1_accept_o, p0_accept_o} !== 2'b00) begin bad++; $display("FAIL rst_accept got=%b exp=00", {p1_accept_o, p0_accept_o}); end
    total++; if ({mem_rd_o, mem_wr_o, mem_flush_o, mem_invalidate_o} !== 7'h0) begin bad++; $display("FAIL rst_strobes got=%h exp=0", {mem_rd_o, mem_wr_o, mem_flush_o, mem_invalidate_o}); end
    total++; if (mem_addr_o !== 32'h0 || mem_req_tag_o !== 11'h0) begin bad++; $display("FAIL rst_fields got=%h/%h exp=0/0", mem_addr_o, mem_req_tag_o); end
    total++; if ({p1_ack_o, p0_ack_o, p1_error_o, p0_error_o} !== 4'h0) begin bad++; $display("FAIL rst_acks got=%b exp=0000", {p1_ack_o, p0_ack_o, p1_error_o, p0_error_o}); end
    total++; if (dbg_state_o !== ST_IDLE || dbg_count_o !== 4'd0) begin bad++; $display("FAIL rst_state got=%b/%0d exp=0/0", dbg_state_o, dbg_count_o); end
    tick();
    // flush-only request counts as a request and expects one ack
    idle_all();
    drv_p1(1'b0, 4'h0, 1'b1, 1'b0, 32'h40, 32'h0, 11'h0F1);
    drv_mem(1'b1, 1'b0, 1'b0, 11'h0, 32'h0);
    #2;
    total++; if (p1_accept_o !== 1'b1 || mem_flush_o !== 1'b1 || mem_addr_o !== 32'h40) begin bad++; $display("FAIL flush_fwd got=%b%b/%h exp=11/40", p1_accept_o, mem_flush_o, mem_addr_o); end
    exp_q.push_back({PORT_P1, 11'h0F1});
    tick();
    idle_all();
    e = exp_q.pop_front();
    drv_mem(1'b0, 1'b1, 1'b0, e[10:0], 32'h0);
    #2;
    total++; if ({p1_ack_o, p0_ack_o} !== 2'b10 || p1_resp_tag_o !== e[10:0]) begin bad++; $display("FAIL flush_ack got=%b/%h exp=10/%h", {p1_ack_o, p0_ack_o}, p1_resp_tag_o, e[10:0]); end
    tick();
    idle_all();
  endtask

  task automatic test_simul_req();
    apply_reset();
    drv_p0(1'b1, 4'h0, 1'b0, 1'b0, 32'h100, 32'h0, 11'h011);
    drv_p1(1'b0, 4'hF, 1'b0, 1'b0, 32'h200, 32'hDEADBEEF, 11'h022);
    drv_mem(1'b1, 1'b0, 1'b0, 11'h0, 32'h0);
    #2;
    total++; if ({p1_accept_o, p0_accept_o} !== 2'b01) begin bad++; $display("FAIL sim_grant0 got=%b exp=01", {p1_accept_o, p0_accept_o}); end
    total++; if (mem_addr_o !== 32'h100 || mem_rd_o !== 1'b1 || mem_req_tag_o !== 11'h011) begin bad++; $display("FAIL sim_fwd0 got=%h/%b/%h exp=100/1/011", mem_addr_o, mem_rd_o, mem_req_tag_o); end
    exp_q.push_back({PORT_P0, 11'h011});
    tick();
    drv_p0(1'b0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 11'h0);
    #2;
    total++; if ({p1_accept_o, p0_accept_o} !== 2'b10) begin bad++; $display("FAIL sim_grant1 got=%b exp=10", {p1_accept_o, p0_accept_o}); end
    total++; if (mem_addr_o !== 32'h200 || mem_wr_o !== 4'hF || mem_data_wr_o !== 32'hDEADBEEF) begin bad++; $display("FAIL sim_fwd1 got=%h/%h/%h exp=200/f/deadbeef", mem_addr_o, mem_wr_o, mem_data_wr_o); end
    exp_q.push_back({PORT_P1, 11'h022});
    tick();
    idle_all();
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      drv_mem(1'b0, 1'b1, 1'b0, e[10:0], 32'h11110000 + 32'(k));
      #2;
      total++; if ({p1_ack_o, p0_ack_o} !== (e[11] ? 2'b10 : 2'b01)) begin bad++; $display("FAIL sim_ack%0d got=%b exp=%b", k, {p1_ack_o, p0_ack_o}, (e[11] ? 2'b10 : 2'b01)); end
      total++; if ((e[11] ? p1_data_rd_o : p0_data_rd_o) !== 32'h11110000 + 32'(k)) begin bad++; $display("FAIL sim_data%0d got=%h exp=%h", k, (e[11] ? p1_data_rd_o : p0_data_rd_o), 32'h11110000 + 32'(k)); end
      tick();
    end
    idle_all();
  endtask

  task automatic test_stall();
    apply_reset();
    drv_p1(1'b1, 4'h0, 1'b0, 1'b0, 32'h300, 32'h0, 11'h031);
    for (int c = 0; c < 3; c++) begin
      if (c >= 1) drv_p0(1'b1, 4'h0, 1'b0, 1'b0, 32'h400, 32'h0, 11'h041);
      #2;
      total++; if (mem_addr_o !== 32'h300 || {p1_accept_o, p0_accept_o} !== 2'b00) begin bad++; $display("FAIL stall_c%0d got=%h/%b exp=300/00", c, mem_addr_o, {p1_accept_o, p0_accept_o}); end
      if (c >= 1) begin
        total++; if (dbg_state_o !== ST_LOCKED) begin bad++; $display("FAIL stall_lock%0d got=%b exp=1", c, dbg_state_o); end
      end
      tick();
    end
    drv_mem(1'b1, 1'b0, 1'b0, 11'h0, 32'h0);
    #2;
    total++; if (mem_addr_o !== 32'h300 || {p1_accept_o, p0_accept_o} !== 2'b10) begin bad++; $display("FAIL stall_acc1 got=%h/%b exp=300/10", mem_addr_o, {p1_accept_o, p0_accept_o}); end
    exp_q.push_back({PORT_P1, 11'h031});
    tick();
    drv_p1(1'b0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 11'h0);
    #2;
    total++; if (mem_addr_o !== 32'h400 || {p1_accept_o, p0_accept_o} !== 2'b01) begin bad++; $display("FAIL stall_acc0 got=%h/%b exp=400/01", mem_addr_o, {p1_accept_o, p0_accept_o}); end
    exp_q.push_back({PORT_P0, 11'h041});
    tick();
    idle_all();
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      drv_mem(1'b0, 1'b1, 1'b0, e[10:0], 32'h0);
      #2;
      total++; if ({p1_ack_o, p0_ack_o} !== (e[11] ? 2'b10 : 2'b01) || (e[11] ? p1_resp_tag_o : p0_resp_tag_o) !== e[10:0]) begin bad++; $display("FAIL stall_ack%0d got=%b exp=%b", k, {p1_ack_o, p0_ack_o}, (e[11] ? 2'b10 : 2'b01)); end
      tick();
    end
    idle_all();
  endtask

  task automatic test_outstanding();
    apply_reset();
    drv_mem(1'b1, 1'b0, 1'b0, 11'h0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      drv_p0(1'b1, 4'h0, 1'b0, 1'b0, 32'h500 + 32'(4 * k), 32'h0, 11'h050 + 11'(k));
      #2;
      total++; if (p0_accept_o !== 1'b1) begin bad++; $display("FAIL out_acc%0d got=%b exp=1", k, p0_accept_o); end
      exp_q.push_back({PORT_P0, 11'h050 + 11'(k)});
      tick();
    end
    drv_p0(1'b1, 4'h0, 1'b0, 1'b0, 32'h508, 32'h0, 11'h052);
    for (int c = 0; c < 2; c++) begin
      #2;
      total++; if (p0_accept_o !== 1'b0 || mem_rd_o !== 1'b0 || dbg_count_o !== 4'd2) begin bad++; $display("FAIL out_block%0d got=%b/%b/%0d exp=0/0/2", c, p0_accept_o, mem_rd_o, dbg_count_o); end
      tick();
    end
    e = exp_q.pop_front();
    drv_mem(1'b1, 1'b1, 1'b0, e[10:0], 32'h0);
    #2;
    total++; if (p0_accept_o !== 1'b0 || mem_rd_o !== 1'b0) begin bad++; $display("FAIL out_fullack got=%b/%b exp=0/0", p0_accept_o, mem_rd_o); end
    total++; if (p0_ack_o !== 1'b1 || p0_resp_tag_o !== e[10:0]) begin bad++; $display("FAIL out_ack got=%b/%h exp=1/%h", p0_ack_o, p0_resp_tag_o, e[10:0]); end
    tick();
    drv_mem(1'b1, 1'b0, 1'b0, 11'h0, 32'h0);
    #2;
    total++; if (p0_accept_o !== 1'b1 || mem_addr_o !== 32'h508) begin bad++; $display("FAIL out_resume got=%b/%h exp=1/508", p0_accept_o, mem_addr_o); end
    exp_q.push_back({PORT_P0, 11'h052});
    tick();
    idle_all();
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      drv_mem(1'b0, 1'b1, 1'b0, e[10:0], 32'h0);
      #2;
      total++; if ({p1_ack_o, p0_ack_o} !== 2'b01 || p0_resp_tag_o !== e[10:0]) begin bad++; $display("FAIL out_drain%0d got=%b/%h exp=01/%h", k, {p1_ack_o, p0_ack_o}, p0_resp_tag_o, e[10:0]); end
      tick();
    end
    idle_all();
  endtask

  task automatic test_error_route();
    apply_reset();
    drv_p1(1'b1, 4'h0, 1'b0, 1'b0, 32'h600, 32'h0, 11'h033);
    drv_mem(1'b1, 1'b0, 1'b0, 11'h0, 32'h0);
    #2;
    total++; if (p1_accept_o !== 1'b1) begin bad++; $display("FAIL err_acc got=%b exp=1", p1_accept_o); end
    exp_q.push_back({PORT_P1, 11'h033});
    tick();
    idle_all();
    e = exp_q.pop_front();
    drv_mem(1'b0, 1'b1, 1'b1, 11'h2A5, 32'hCAFE0001);
    #2;
    total++; if (p1_ack_o !== 1'b1 || p1_error_o !== 1'b1 || p1_resp_tag_o !== 11'h2A5) begin bad++; $display("FAIL err_p1 got=%b%b/%h exp=11/2a5", p1_ack_o, p1_error_o, p1_resp_tag_o); end
    total++; if (p0_ack_o !== 1'b0 || p0_error_o !== 1'b0 || p0_resp_tag_o !== 11'h0 || p0_data_rd_o !== 32'h0) begin bad++; $display("FAIL err_p0 got=%b%b/%h/%h exp=00/0/0", p0_ack_o, p0_error_o, p0_resp_tag_o, p0_data_rd_o); end
    total++; if (e[11] !== PORT_P1 || p1_data_rd_o !== 32'hCAFE0001) begin bad++; $display("FAIL err_data got=%h exp=cafe0001", p1_data_rd_o); end
    tick();
    idle_all();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drv_mem(1'b1, 1'b0, 1'b0, 11'h0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      drv_p0(1'b1, 4'h0, 1'b0, 1'b0, 32'h700 + 32'(k), 32'h0, 11'h070 + 11'(k));
      #2;
      exp_q.push_back({PORT_P0, 11'h070 + 11'(k)});
      tick();
    end
    idle_all();
    #2;
    total++; if (dbg_count_o !== 4'd2) begin bad++; $display("FAIL mid_pre got=%0d exp=2", dbg_count_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    drv_mem(1'b0, 1'b1, 1'b0, 11'h070, 32'h0);
    #2;
    total++; if ({p1_ack_o, p0_ack_o} !== 2'b00) begin bad++; $display("FAIL mid_stray got=%b exp=00", {p1_ack_o, p0_ack_o}); end
    total++; if (dbg_count_o !== 4'd0 || dbg_state_o !== ST_IDLE) begin bad++; $display("FAIL mid_empty got=%0d/%b exp=0/0", dbg_count_o, dbg_state_o); end
    tick();
    total++; if (dbg_count_o !== 4'd0) begin bad++; $display("FAIL mid_after got=%0d exp=0", dbg_count_o); end
    drv_p0(1'b1, 4'h0, 1'b0, 1'b0, 32'h780, 32'h0, 11'h078);
    drv_p1(1'b1, 4'h0, 1'b0, 1'b0, 32'h790, 32'h0, 11'h079);
    drv_mem(1'b1, 1'b0, 1'b0, 11'h0, 32'h0);
    #2;
    total++; if ({p1_accept_o, p0_accept_o} !== 2'b01) begin bad++; $display("FAIL mid_prio got=%b exp=01", {p1_accept_o, p0_accept_o}); end
    exp_q.push_back({PORT_P0, 11'h078});
    tick();
    idle_all();
    e = exp_q.pop_front();
    drv_mem(1'b0, 1'b1, 1'b0, e[10:0], 32'h0);
    #2;
    total++; if ({p1_ack_o, p0_ack_o} !== 2'b01 || p0_resp_tag_o !== e[10:0]) begin bad++; $display("FAIL mid_ack got=%b/%h exp=01/%h", {p1_ack_o, p0_ack_o}, p0_resp_tag_o, e[10:0]); end
    tick();
    idle_all();
  endtask

  task automatic test_push_pop();
    apply_reset();
    drv_p0(1'b1, 4'h0, 1'b0, 1'b0, 32'h800, 32'h0, 11'h0A1);
    drv_mem(1'b1, 1'b0, 1'b0, 11'h0, 32'h0);
    #2;
    exp_q.push_back({PORT_P0, 11'h0A1});
    tick();
    idle_all();
    drv_p1(1'b1, 4'h0, 1'b0, 1'b0, 32'h810, 32'h0, 11'h0B2);
    e = exp_q.pop_front();
    drv_mem(1'b1, 1'b1, 1'b0, e[10:0], 32'h0);
    #2;
    total++; if (p1_accept_o !== 1'b1 || {p1_ack_o, p0_ack_o} !== 2'b01 || p0_resp_tag_o !== e[10:0]) begin bad++; $display("FAIL pp_same got=%b/%b/%h exp=1/01/%h", p1_accept_o, {p1_ack_o, p0_ack_o}, p0_resp_tag_o, e[10:0]); end
    exp_q.push_back({PORT_P1, 11'h0B2});
    tick();
    idle_all();
    #2;
    total++; if (dbg_count_o !== 4'd1) begin bad++; $display("FAIL pp_count got=%0d exp=1", dbg_count_o); end
    drv_p1(1'b1, 4'h0, 1'b0, 1'b0, 32'h820, 32'h0, 11'h0C3);
    drv_mem(1'b1, 1'b0, 1'b0, 11'h0, 32'h0);
    #2;
    exp_q.push_back({PORT_P1, 11'h0C3});
    tick();
    idle_all();
    drv_p0(1'b1, 4'h0, 1'b0, 1'b0, 32'h830, 32'h0, 11'h0D4);
    e = exp_q.pop_front();
    drv_mem(1'b1, 1'b1, 1'b0, e[10:0], 32'h0);
    #2;
    total++; if (p0_accept_o !== 1'b0 || {p1_ack_o, p0_ack_o} !== 2'b10 || p1_resp_tag_o !== e[10:0]) begin bad++; $display("FAIL pp_full got=%b/%b/%h exp=0/10/%h", p0_accept_o, {p1_ack_o, p0_ack_o}, p1_resp_tag_o, e[10:0]); end
    tick();
    e = exp_q.pop_front();
    drv_mem(1'b1, 1'b1, 1'b0, e[10:0], 32'h0);
    #2;
    total++; if (p0_accept_o !== 1'b1 || {p1_ack_o, p0_ack_o} !== 2'b10 || p1_resp_tag_o !== e[10:0]) begin bad++; $display("FAIL pp_order got=%b/%b/%h exp=1/10/%h", p0_accept_o, {p1_ack_o, p0_ack_o}, p1_resp_tag_o, e[10:0]); end
    exp_q.push_back({PORT_P0, 11'h0D4});
    tick();
    idle_all();
    e = exp_q.pop_front();
    drv_mem(1'b0, 1'b1, 1'b0, e[10:0], 32'h0);
    #2;
    total++; if ({p1_ack_o, p0_ack_o} !== 2'b01 || p0_resp_tag_o !== e[10:0]) begin bad++; $display("FAIL pp_last got=%b/%h exp=01/%h", {p1_ack_o, p0_ack_o}, p0_resp_tag_o, e[10:0]); end
    tick();
    idle_all();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a0, a1;
    logic [10:0] t0, t1;
    logic        exp_port;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      a0 = $urandom;
      a1 = $urandom;
      t0 = 11'($urandom_range(0, 2047));
      t1 = 11'($urandom_range(0, 2047));
      drv_p0(1'b1, 4'h0, 1'b0, 1'b0, a0, 32'h0, t0);
      drv_p1(1'b1, 4'h0, 1'b0, 1'b0, a1, 32'h0, t1);
      if (k > 0) begin
        e = exp_q.pop_front();
        drv_mem(1'b1, 1'b1, 1'b0, e[10:0], 32'h0);
      end else begin
        drv_mem(1'b1, 1'b0, 1'b0, 11'h0, 32'h0);
      end
      exp_port = (k % 2 == 1);
      #2;
      total++; if ({p1_accept_o, p0_accept_o} !== (exp_port ? 2'b10 : 2'b01) || mem_addr_o !== (exp_port ? a1 : a0)) begin bad++; $display("FAIL b2b_grant%0d got=%b/%h exp=%b/%h", k, {p1_accept_o, p0_accept_o}, mem_addr_o, (exp_port ? 2'b10 : 2'b01), (exp_port ? a1 : a0)); end
      if (k > 0) begin
        total++; if ({p1_ack_o, p0_ack_o} !== (e[11] ? 2'b10 : 2'b01) || (e[11] ? p1_resp_tag_o : p0_resp_tag_o) !== e[10:0]) begin bad++; $display("FAIL b2b_ack%0d got=%b exp=%b", k, {p1_ack_o, p0_ack_o}, (e[11] ? 2'b10 : 2'b01)); end
      end
      exp_q.push_back({exp_port, exp_port ? t1 : t0});
      tick();
    end
    idle_all();
    e = exp_q.pop_front();
    drv_mem(1'b0, 1'b1, 1'b0, e[10:0], 32'h0);
    #2;
    total++; if ({p1_ack_o, p0_ack_o} !== (e[11] ? 2'b10 : 2'b01)) begin bad++; $display("FAIL b2b_drain got=%b exp=%b", {p1_ack_o, p0_ack_o}, (e[11] ? 2'b10 : 2'b01)); end
    tick();
    idle_all();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_all();
    test_reset();
    test_simul_req();
    test_stall();
    test_outstanding();
    test_error_route();
    test_reset_mid();
    test_push_pop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
